pc_unit: RTL and testbench

- Parametrised successor to the single-register program counter.
- Holds the fetch PC and computes next-PC each cycle from these sources: sequential increment, PC-relative branch, absolute jump, subroutine return, trap vector.
- Supports stall hold.
- Has an optional return-address stack (RAS).
- Sits between the branch/jump resolution logic and instruction-memory fetch.

---
 rtl/pc_pkg.sv | 10 +
 rtl/pc_ras.sv | 39 +++
 rtl/pc_unit.sv | 83 ++++++++
 tb/tb_pc_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC source encoding and default constants for the program counter
// Contents: pc_src_e (winning next-PC source), default PC_W/INC/RESET_PC/TRAP_VEC/RAS_DEPTH.
package pc_pkg;
  typedef enum logic [2:0] {SRC_SEQ, SRC_HOLD, SRC_BR, SRC_JMP, SRC_RET, SRC_TRAP} pc_src_e;
  localparam int PC_W_DEF = 16;
  localparam int INC_DEF = 1;
  localparam int RESET_PC_DEF = 0;
  localparam int TRAP_VEC_DEF = 4;
  localparam int RAS_DEPTH_DEF = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with occupancy counter
// Ports: clk, rst (async active-low), push/pop/push_data requests, top (newest entry),
//        empty (no entries), full (RAS_DEPTH entries).
// Push when full overwrites the oldest entry; push+pop together replaces the top in place.
// The caller never pops an empty stack.
module pc_ras #(
  parameter int PC_W = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [AW-1:0] ptr, tos;
  logic [CW-1:0] cnt;
  // ptr is the next write slot; the slot just below it is the top of stack
  assign tos = ptr - 1'b1;
  assign top = mem[tos];
  assign empty = cnt == '0;
  assign full = cnt == CW'(RAS_DEPTH);
  always_ff @(posedge clk)
    if (push) mem[pop ? tos : ptr] <= push_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push != pop) begin
      ptr <= push ? ptr + 1'b1 : tos;
      cnt <= push ? (full ? cnt : cnt + 1'b1) : cnt - 1'b1;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with prioritised next-PC select and optional return stack
// Ports: clk, rst (async active-low); requests stall, br_taken/br_offset, jmp/jmp_target,
//        call, ret, trap; outputs pc_out (registered PC), pc_plus (pc_out+INC), pc_valid,
//        ras_empty, ras_full, ras_err (sticky underflow / illegal return).
// Build option: define PC_RAS_EN to include the return-address stack; without it every
// ret traps and flags ras_err, call is ignored, and the port list is unchanged.
module pc_unit
  import pc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INC = INC_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int TRAP_VEC = TRAP_VEC_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_offset,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);
  pc_src_e src;
  logic [PC_W-1:0] ras_top, pc_nxt;
  logic ras_hit;
  assign pc_plus = pc_out + PC_W'(INC);
  always_comb begin
    src = trap ? SRC_TRAP : ret ? SRC_RET : jmp ? SRC_JMP : br_taken ? SRC_BR : stall ? SRC_HOLD : SRC_SEQ;
    // a return only succeeds with a stacked address; otherwise it traps
    ras_hit = src == SRC_RET && !ras_empty;
    pc_nxt = src == SRC_TRAP ? PC_W'(TRAP_VEC)
           : src == SRC_RET  ? (ras_hit ? ras_top : PC_W'(TRAP_VEC))
           : src == SRC_JMP  ? jmp_target
           : src == SRC_BR   ? pc_out + br_offset
           : src == SRC_HOLD ? pc_out
           : pc_plus;
  end
`ifdef PC_RAS_EN
  logic push, pop;
  // the stack only moves on a real redirect edge, never during the post-reset hold edge
  assign pop = pc_valid && ras_hit;
  assign push = pc_valid && call && (src == SRC_JMP || ras_hit);
  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_data(pc_plus),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full)
  );
`else
  logic unused_call;
  assign unused_call = call;
  assign ras_top = '0;
  assign ras_empty = 1'b1;
  assign ras_full = 1'b0;
`endif
  // first edge after reset only raises pc_valid so RESET_PC is the first fetched address
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_out <= PC_W'(RESET_PC);
      pc_valid <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      if (pc_valid) begin
        pc_out <= pc_nxt;
        ras_err <= ras_err | (src == SRC_RET && !ras_hit);
      end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a behavioural model
module tb_pc_unit;
  localparam int DEPTH = 4;
  localparam logic [15:0] TV = 16'h0004;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic call = 1'b0, ret = 1'b0, trap = 1'b0;
  logic [15:0] br_offset = '0, jmp_target = '0;
  logic [15:0] pc_out, pc_plus;
  logic pc_valid, ras_empty, ras_full, ras_err;
  int checks = 0, errors = 0;
  logic [15:0] m_pc;
  logic m_valid, m_err;
  logic [15:0] m_stk[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .jmp(jmp), .jmp_target(jmp_target), .call(call), .ret(ret), .trap(trap),
    .pc_out(pc_out), .pc_plus(pc_plus), .pc_valid(pc_valid), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err)
  );

  task automatic clr();
    {stall, br_taken, jmp, call, ret, trap} = '0;
    br_offset = '0;
    jmp_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_pc = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // advance the reference model by one edge using the current requests, then clock
  task automatic tick();
`ifdef PC_RAS_EN
    logic [15:0] r;
`endif
    if (m_valid) begin
      if (trap) m_pc = TV;
      else if (ret) begin
`ifdef PC_RAS_EN
        if (m_stk.size() > 0) begin
          r = m_stk.pop_back();
          if (call) m_stk.push_back(m_pc + 16'd1);
          m_pc = r;
        end else begin
          m_pc = TV;
          m_err = 1'b1;
        end
`else
        m_pc = TV;
        m_err = 1'b1;
`endif
      end else if (jmp) begin
`ifdef PC_RAS_EN
        if (call) begin
          if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
          m_stk.push_back(m_pc + 16'd1);
        end
`endif
        m_pc = jmp_target;
      end else if (br_taken) m_pc = m_pc + br_offset;
      else if (!stall) m_pc = m_pc + 16'd1;
    end
    if (rst) m_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    clr();
    do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr();
    do_reset();
    #2;
    checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 16'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", ras_full); end
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", ras_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL release_valid[%0d] got %b exp 1", i, pc_valid); end
      checks++; if (pc_out !== 16'(i)) begin errors++; $display("FAIL release_pc[%0d] got %h exp %h", i, pc_out, 16'(i)); end
    end
    #3;
    do_reset();
    #1;
    checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL midreset_pc got %h exp 0000", pc_out); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", pc_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++; if (pc_out !== 16'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL rerelease got pc=%h v=%b exp pc=0000 v=1", pc_out, pc_valid); end
  endtask

  task automatic test_stall_redirect();
    clr();
    jmp = 1'b1;
    jmp_target = 16'h0010;
    tick();
    clr();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 16'h0010) begin errors++; $display("FAIL stall_hold[%0d] got %h exp 0010", i, pc_out); end
    end
    br_taken = 1'b1;
    br_offset = 16'hFFF8;
    tick();
    checks++; if (pc_out !== 16'h0008) begin errors++; $display("FAIL branch_over_stall got %h exp 0008", pc_out); end
    clr();
  endtask

  task automatic test_priority_wrap();
    clr();
    trap = 1'b1;
    jmp = 1'b1;
    jmp_target = 16'h0100;
    tick();
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL trap_priority got %h exp 0004", pc_out); end
    clr();
    jmp = 1'b1;
    jmp_target = 16'hFFFF;
    tick();
    clr();
    checks++; if (pc_plus !== 16'h0000) begin errors++; $display("FAIL pc_plus_wrap got %h exp 0000", pc_plus); end
    tick();
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h exp 0000", pc_out); end
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    restart();
    jmp = 1'b1;
    jmp_target = 16'h0010;
    tick();
    call = 1'b1;
    jmp_target = 16'h0200;
    tick();
    clr();
    tick();
    checks++; if (pc_out !== 16'h0201) begin errors++; $display("FAIL ras_seq got %h exp 0201", pc_out); end
    jmp = 1'b1;
    call = 1'b1;
    jmp_target = 16'h0300;
    tick();
    clr();
    ret = 1'b1;
    tick();
    checks++; if (pc_out !== 16'h0202) begin errors++; $display("FAIL ras_ret1 got %h exp 0202", pc_out); end
    tick();
    checks++; if (pc_out !== 16'h0011) begin errors++; $display("FAIL ras_ret2 got %h exp 0011", pc_out); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ras_empty_end got %b exp 1", ras_empty); end
    clr();
  endtask

  task automatic test_ras_overflow();
    restart();
    for (int i = 0; i < 5; i++) begin
      jmp = 1'b1;
      call = 1'b1;
      jmp_target = 16'h1000 + 16'(i * 256);
      tick();
      checks++; if (pc_out !== jmp_target) begin errors++; $display("FAIL call[%0d] got %h exp %h", i, pc_out, jmp_target); end
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ras_full got %b exp 1", ras_full); end
    clr();
    ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc_out !== 16'h1301 - 16'(i * 256)) begin errors++; $display("FAIL ovf_ret[%0d] got %h exp %h", i, pc_out, 16'h1301 - 16'(i * 256)); end
    end
    checks++; if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin errors++; $display("FAIL ovf_drained got empty=%b err=%b exp 1 0", ras_empty, ras_err); end
    tick();
    checks++; if (pc_out !== TV) begin errors++; $display("FAIL underflow_pc got %h exp %h", pc_out, TV); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b exp 1", ras_err); end
    clr();
    repeat (3) tick();
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", ras_err); end
    do_reset();
    #1;
    checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", ras_err); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
`else
  task automatic test_no_ras();
    restart();
    ret = 1'b1;
    tick();
    checks++; if (pc_out !== TV) begin errors++; $display("FAIL noras_ret_pc got %h exp %h", pc_out, TV); end
    checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL noras_ret_err got %b exp 1", ras_err); end
    clr();
    jmp = 1'b1;
    call = 1'b1;
    jmp_target = 16'h0050;
    tick();
    checks++; if (pc_out !== 16'h0050) begin errors++; $display("FAIL noras_call_pc got %h exp 0050", pc_out); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL noras_flags got empty=%b full=%b exp 1 0", ras_empty, ras_full); end
    clr();
  endtask
`endif

  task automatic test_random();
    logic exp_empty;
    restart();
    for (int n = 0; n < 400; n++) begin
      trap = $urandom_range(15) == 0;
      ret = $urandom_range(5) == 0;
      jmp = $urandom_range(4) == 0;
      call = $urandom_range(1) == 0;
      br_taken = $urandom_range(3) == 0;
      stall = $urandom_range(2) == 0;
      br_offset = 16'($urandom);
      jmp_target = 16'($urandom);
      tick();
`ifdef PC_RAS_EN
      exp_empty = m_stk.size() == 0;
`else
      exp_empty = 1'b1;
`endif
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h exp %h", n, pc_out, m_pc); end
      checks++; if (pc_plus !== m_pc + 16'd1) begin errors++; $display("FAIL rnd_plus[%0d] got %h exp %h", n, pc_plus, m_pc + 16'd1); end
      checks++; if (pc_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, pc_valid, m_valid); end
      checks++; if (ras_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", n, ras_err, m_err); end
      checks++; if (ras_empty !== exp_empty) begin errors++; $display("FAIL rnd_empty[%0d] got %b exp %b", n, ras_empty, exp_empty); end
`ifdef PC_RAS_EN
      checks++; if (ras_full !== (m_stk.size() == DEPTH)) begin errors++; $display("FAIL rnd_full[%0d] got %b exp %b", n, ras_full, m_stk.size() == DEPTH); end
`else
      checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL rnd_full[%0d] got %b exp 0", n, ras_full); end
`endif
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_priority_wrap();
`ifdef PC_RAS_EN
    test_ras();
    test_ras_overflow();
`else
    test_no_ras();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
